branch_predictor: RTL

Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. It is looked up combinationally with the fetch PC in IF and supplies a predicted next PC. It is trained from the branch/jump resolution point in MEM. It replaces the current always-fall-through fetch policy and keeps a misprediction count for performance runs.

---
 rtl/branch_predictor.sv | 116 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating direction counters.
// Looked up combinationally from IF, trained from MEM, with saturating perf counters.
module branch_predictor #(
   parameter int         ENTRIES  = 16,
   parameter logic [1:0] CTR_INIT = 2'b01,
   parameter int         IDX_W    = $clog2(ENTRIES)
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic [31:0] lookup_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_npc,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic        flush,
   output logic [31:0] mispredict_cnt,
   output logic [31:0] update_cnt
);

   localparam int TAG_W = 30 - IDX_W;

   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];

   logic [31:0]      r_mis_cnt;
   logic [31:0]      r_upd_cnt;

   logic [IDX_W-1:0] w_lk_idx;
   logic [TAG_W-1:0] w_lk_tag;
   logic             w_lk_hit;
   logic             w_lk_taken;

   logic [IDX_W-1:0] w_up_idx;
   logic [TAG_W-1:0] w_up_tag;
   logic             w_up_hit;
   logic [1:0]       w_up_ctr;
   logic [1:0]       w_ctr_inc;
   logic [1:0]       w_ctr_dec;
   logic             w_mispred;
   logic             w_unused;

   // pc[1:0] never participates in indexing or tagging
   assign w_unused   = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign w_lk_idx   = lookup_pc[IDX_W+1:2];
   assign w_lk_tag   = lookup_pc[31:IDX_W+2];
   assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][1];

   assign pred_hit   = w_lk_hit;
   assign pred_taken = w_lk_taken;
   assign pred_npc   = w_lk_taken ? r_target[w_lk_idx]
                                  : lookup_pc + 32'd4;

   assign w_up_idx   = upd_pc[IDX_W+1:2];
   assign w_up_tag   = upd_pc[31:IDX_W+2];
   assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
   assign w_up_ctr   = r_ctr[w_up_idx];
   assign w_ctr_inc  = (w_up_ctr == 2'b11) ? 2'b11 : w_up_ctr + 2'b01;
   assign w_ctr_dec  = (w_up_ctr == 2'b00) ? 2'b00 : w_up_ctr - 2'b01;
   assign w_mispred  = upd_en && (upd_taken != upd_pred_taken);

   // flush wins over a same-cycle update
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= CTR_INIT;
         end
      end else if (flush) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
         end
      end else if (upd_en) begin
         if (w_up_hit) begin
            if (upd_taken) begin
               r_ctr[w_up_idx]    <= w_ctr_inc;
               r_target[w_up_idx] <= upd_target;
            end else begin
               r_ctr[w_up_idx]    <= w_ctr_dec;
            end
         end else if (upd_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= upd_target;
            r_ctr[w_up_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_upd_cnt <= '0;
         r_mis_cnt <= '0;
      end else begin
         if (upd_en && (r_upd_cnt != 32'hFFFF_FFFF)) begin
            r_upd_cnt <= r_upd_cnt + 32'd1;
         end
         if (w_mispred && (r_mis_cnt != 32'hFFFF_FFFF)) begin
            r_mis_cnt <= r_mis_cnt + 32'd1;
         end
      end
   end

   assign mispredict_cnt = r_mis_cnt;
   assign update_cnt     = r_upd_cnt;

endmodule
